// File: rtl/rv32_mod_load_store_unit_if.sv
// Load/store unit port bundle: decode/execute request side plus word-wide memory bus.
// Latency: none (wires only).
// Backpressure: lsu_valid/lsu_ready on the request side, mem_req/mem_ack on the bus side.
interface rv32_mod_load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  // Request / completion side
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [3:0]            lsu_req;
  logic                  lsu_wr;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [31:0]           lsu_wdata;
  logic                  lsu_done;
  logic [31:0]           lsu_rdata;
  logic                  lsu_err;
  logic                  lsu_misaligned;
  // Memory bus side
  logic                  mem_req;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_ack;
  logic                  mem_err;

  // The load/store unit itself
  modport master (
    input  lsu_valid, lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    output lsu_ready, lsu_done, lsu_rdata, lsu_err, lsu_misaligned,
    output mem_req, mem_wr, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack, mem_err
  );

  // Requester plus memory model facing the unit
  modport slave (
    output lsu_valid, lsu_req, lsu_wr, lsu_addr, lsu_wdata,
    input  lsu_ready, lsu_done, lsu_rdata, lsu_err, lsu_misaligned,
    input  mem_req, mem_wr, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack, mem_err
  );
endinterface

// File: rtl/rv32_mod_load_store_unit.sv
// RV32 load/store unit: one decoded access per request onto a req/ack word bus; optional RV32_LSU_TIMEOUT_EN.
// Latency: lsu_done 2 cycles after accept with immediate ack; 1 cycle for illegal or misaligned requests.
// Backpressure: lsu_ready low from accept through the done cycle; REQ waits for mem_ack (or times out).
module rv32_mod_load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  rv32_mod_load_store_unit_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            req_q, req_d;        // funct3 width/sign code of the access in flight
  logic                  wr_q, wr_d;
  logic [1:0]            off_q, off_d;        // byte offset, needed to pick the load lane
  logic                  mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]            mem_be_q, mem_be_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  err_q, err_d;
  logic                  mis_q, mis_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  req_legal;
  logic                  req_aligned;
  logic [31:0]           rd_shifted;
  logic [31:0]           rd_ext;

  // Bit 3 of the request code carries no meaning for this unit.
  logic                  unused_req_msb;
  assign unused_req_msb = bus.lsu_req[3];

`ifdef RV32_LSU_TIMEOUT_EN
  logic [31:0]           cnt_q, cnt_d;
`endif

  // Outputs straight from state and registers so reset clears them asynchronously
  assign bus.lsu_ready      = (state_q == S_IDLE);
  assign bus.lsu_done       = (state_q == S_DONE);
  assign bus.mem_req        = (state_q == S_REQ);
  assign bus.mem_wr         = mem_wr_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_be         = mem_be_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.lsu_err        = err_q;
  assign bus.lsu_misaligned = mis_q;
  assign bus.lsu_rdata      = rdata_q;

  // Decode legality/alignment of the incoming request and align/extend returning load data
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b0;
    rd_shifted  = '0;
    rd_ext      = '0;

    case (bus.lsu_req[2:0])
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = !(bus.lsu_wr && bus.lsu_req[2]);
      default:                                req_legal = 1'b0;
    endcase

    case (bus.lsu_req[1:0])
      2'b00:   req_aligned = 1'b1;
      2'b01:   req_aligned = (bus.lsu_addr[0] == 1'b0);
      default: req_aligned = (bus.lsu_addr[1:0] == 2'b00);
    endcase

    rd_shifted = bus.mem_rdata >> {off_q, 3'b000};
    case (req_q[1:0])
      2'b00:   rd_ext = {{24{~req_q[2] & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   rd_ext = {{16{~req_q[2] & rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  // Next-state and register updates for IDLE -> (REQ) -> DONE -> IDLE
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    wr_d        = wr_q;
    off_d       = off_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    mis_d       = mis_q;
    rdata_d     = rdata_q;
`ifdef RV32_LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.lsu_valid) begin
          req_d = bus.lsu_req[2:0];
          wr_d  = bus.lsu_wr;
          off_d = bus.lsu_addr[1:0];
          if (!req_legal) begin
            err_d   = 1'b1;
            mis_d   = 1'b0;
            rdata_d = '0;
            state_d = S_DONE;
          end else if (!req_aligned) begin
            err_d   = 1'b1;
            mis_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end else begin
            err_d      = 1'b0;
            mis_d      = 1'b0;
            mem_wr_d   = bus.lsu_wr;
            mem_addr_d = {bus.lsu_addr[ADDR_WIDTH-1:2], 2'b00};
            case (bus.lsu_req[1:0])
              2'b00: begin
                mem_be_d    = 4'b0001 << bus.lsu_addr[1:0];
                mem_wdata_d = {4{bus.lsu_wdata[7:0]}};
              end
              2'b01: begin
                mem_be_d    = 4'b0011 << bus.lsu_addr[1:0];
                mem_wdata_d = {2{bus.lsu_wdata[15:0]}};
              end
              default: begin
                mem_be_d    = 4'b1111;
                mem_wdata_d = bus.lsu_wdata;
              end
            endcase
`ifdef RV32_LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = S_REQ;
          end
        end
      end

      S_REQ: begin
        if (bus.mem_ack) begin
          err_d = bus.mem_err;
          mis_d = 1'b0;
          if (bus.mem_err) begin
            rdata_d = '0;
          end else if (!wr_q) begin
            rdata_d = rd_ext;
          end
          state_d = S_DONE;
`ifdef RV32_LSU_TIMEOUT_EN
        end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted REQ cycle passed without ack: abandon the bus access
          err_d   = 1'b1;
          mis_d   = 1'b0;
          rdata_d = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
`endif
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      req_q       <= '0;
      wr_q        <= 1'b0;
      off_q       <= '0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      wr_q        <= wr_d;
      off_q       <= off_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef RV32_LSU_TIMEOUT_EN
  // REQ-cycle counter for the bus timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
module tb_rv32_mod_load_store_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32_mod_load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  rv32_mod_load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble_request();
    bus.lsu_valid = 1'b0;
    bus.lsu_req   = 4'($urandom);
    bus.lsu_wr    = 1'($urandom);
    bus.lsu_addr  = $urandom;
    bus.lsu_wdata = $urandom;
  endtask

  // One access with the reference model computed from the access rules.
  task automatic do_access(input logic [3:0] req, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd,
                           input logic merr, input int delay);
    logic [2:0]  f;
    bit          legal, aligned, sgn;
    int          sz, off, be_i;
    longint      v;
    logic [31:0] exp_wd, exp_ld;
    f       = req[2:0];
    legal   = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5) && !(wr && f[2]);
    sz      = 1 << f[1:0];
    off     = int'(addr % 4);
    aligned = legal && ((addr % sz) == 0);
    sgn     = (f[2] == 1'b0);
    be_i    = ((1 << sz) - 1) << off;
    if (sz == 1)      exp_wd = (wdata & 32'hFF) * 32'h0101_0101;
    else if (sz == 2) exp_wd = (wdata & 32'hFFFF) * 32'h0001_0001;
    else              exp_wd = wdata;
    v = (longint'(rd) >> (8 * off)) & ((64'h1 << (8 * sz)) - 1);
    if (sz < 4 && sgn && v >= (64'h1 << (8 * sz - 1))) v = v - (64'h1 << (8 * sz));
    exp_ld = v[31:0];

    chk("ready_before_accept", 32'(bus.lsu_ready), 32'd1);
    bus.lsu_valid = 1'b1;
    bus.lsu_req   = req;
    bus.lsu_wr    = wr;
    bus.lsu_addr  = addr;
    bus.lsu_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    scramble_request();

    if (!aligned) begin
      chk("err_done",      32'(bus.lsu_done),       32'd1);
      chk("err_flag",      32'(bus.lsu_err),        32'd1);
      chk("err_misalign",  32'(bus.lsu_misaligned), legal ? 32'd1 : 32'd0);
      chk("err_no_memreq", 32'(bus.mem_req),        32'd0);
      chk("err_not_ready", 32'(bus.lsu_ready),      32'd0);
      exp_rdata = 32'h0;
      chk("err_rdata",     bus.lsu_rdata,           exp_rdata);
    end else begin
      for (int c = 0; c <= delay; c++) begin
        chk("req_mem_req",  32'(bus.mem_req),  32'd1);
        chk("req_mem_wr",   32'(bus.mem_wr),   32'(wr));
        chk("req_mem_addr", bus.mem_addr,      addr & 32'hFFFF_FFFC);
        chk("req_mem_be",   32'(bus.mem_be),   32'(be_i[3:0]));
        if (wr) chk("req_mem_wdata", bus.mem_wdata, exp_wd);
        chk("req_no_done",  32'(bus.lsu_done), 32'd0);
        chk("req_not_ready", 32'(bus.lsu_ready), 32'd0);
        if (c == delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rd;
          bus.mem_err   = merr;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = $urandom;
          bus.mem_err   = 1'($urandom);
        end
        @(negedge clk);
      end
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
      chk("ack_done",       32'(bus.lsu_done),       32'd1);
      chk("ack_err",        32'(bus.lsu_err),        32'(merr));
      chk("ack_misaligned", 32'(bus.lsu_misaligned), 32'd0);
      chk("ack_req_dropped", 32'(bus.mem_req),       32'd0);
      if (merr) exp_rdata = 32'h0;
      else if (!wr) exp_rdata = exp_ld;
      chk("ack_rdata",      bus.lsu_rdata,           exp_rdata);
    end

    @(negedge clk);
    chk("post_done_low",  32'(bus.lsu_done),  32'd0);
    chk("post_ready",     32'(bus.lsu_ready), 32'd1);
    chk("post_rdata_held", bus.lsu_rdata,     exp_rdata);
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_ack   = 1'b0;
    bus.mem_err   = 1'b0;
    bus.mem_rdata = 32'h0;
    scramble_request();
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_ready",   32'(bus.lsu_ready),      32'd1);
    chk("rst_done",    32'(bus.lsu_done),       32'd0);
    chk("rst_mem_req", 32'(bus.mem_req),        32'd0);
    chk("rst_mem_wr",  32'(bus.mem_wr),         32'd0);
    chk("rst_mem_be",  32'(bus.mem_be),         32'd0);
    chk("rst_addr",    bus.mem_addr,            32'd0);
    chk("rst_wdata",   bus.mem_wdata,           32'd0);
    chk("rst_rdata",   bus.lsu_rdata,           32'd0);
    chk("rst_err",     32'(bus.lsu_err),        32'd0);
    chk("rst_mis",     32'(bus.lsu_misaligned), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    do_access(4'b0000, 1'b0, 32'h0000_0103, 32'h0,          32'h8011_2233, 1'b0, 0); // LB
    do_access(4'b0101, 1'b0, 32'h0000_0202, 32'h0,          32'hBEEF_1234, 1'b0, 3); // LHU
    do_access(4'b0000, 1'b1, 32'h0000_0301, 32'h1234_56AB,  32'h0,         1'b0, 1); // SB
    do_access(4'b0010, 1'b1, 32'h0000_0304, 32'hDEAD_BEEF,  32'h0,         1'b0, 0); // SW
    do_access(4'b0010, 1'b0, 32'h0000_0402, 32'h0,          32'h0,         1'b0, 0); // LW misaligned
    do_access(4'b0011, 1'b0, 32'h0000_0500, 32'h0,          32'h0,         1'b0, 0); // illegal load
    do_access(4'b0100, 1'b1, 32'h0000_0600, 32'h1111_2222,  32'h0,         1'b0, 0); // illegal store
    do_access(4'b0010, 1'b0, 32'h0000_0700, 32'h0,          32'h1234_5678, 1'b0, 0); // LW good
    do_access(4'b0010, 1'b0, 32'h0000_0704, 32'h0,          32'hCAFE_F00D, 1'b1, 2); // LW bus error

    // Ack/err outside REQ must be ignored
    bus.mem_ack   = 1'b1;
    bus.mem_err   = 1'b1;
    bus.mem_rdata = 32'hA5A5_A5A5;
    repeat (2) begin
      @(negedge clk);
      chk("stray_ack_no_done", 32'(bus.lsu_done),  32'd0);
      chk("stray_ack_ready",   32'(bus.lsu_ready), 32'd1);
      chk("stray_ack_rdata",   bus.lsu_rdata,      exp_rdata);
    end
    bus.mem_ack = 1'b0;
    bus.mem_err = 1'b0;

    // Reset in the middle of REQ
    bus.lsu_valid = 1'b1;
    bus.lsu_req   = 4'b0010;
    bus.lsu_wr    = 1'b0;
    bus.lsu_addr  = 32'h0000_0800;
    @(posedge clk);
    @(negedge clk);
    scramble_request();
    chk("midreq_mem_req", 32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midreq_rst_drop", 32'(bus.mem_req),   32'd0);
    chk("midreq_rst_rdy",  32'(bus.lsu_ready), 32'd1);
    exp_rdata = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("midreq_no_done", 32'(bus.lsu_done), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("midreq_after_done",  32'(bus.lsu_done), 32'd0);
    chk("midreq_after_rdata", bus.lsu_rdata,     exp_rdata);

`ifdef RV32_LSU_TIMEOUT_EN
    // No ack: abort after TIMEOUT_CYCLES=4 REQ cycles, then a late ack is ignored
    bus.lsu_valid = 1'b1;
    bus.lsu_req   = 4'b0000;
    bus.lsu_wr    = 1'b0;
    bus.lsu_addr  = 32'h0000_0901;
    @(posedge clk);
    @(negedge clk);
    scramble_request();
    for (int c = 0; c < 4; c++) begin
      chk("to_mem_req", 32'(bus.mem_req), 32'd1);
      @(negedge clk);
    end
    exp_rdata = 32'h0;
    chk("to_done",    32'(bus.lsu_done),       32'd1);
    chk("to_err",     32'(bus.lsu_err),        32'd1);
    chk("to_mis",     32'(bus.lsu_misaligned), 32'd0);
    chk("to_rdata",   bus.lsu_rdata,           exp_rdata);
    chk("to_req_low", 32'(bus.mem_req),        32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h7777_7777;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("to_late_ack_no_done", 32'(bus.lsu_done), 32'd0);
    @(negedge clk);
    chk("to_late_ack_idle",    32'(bus.lsu_done), 32'd0);
    chk("to_late_ack_rdata",   bus.lsu_rdata,     exp_rdata);
`endif

    // Randomized accesses
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_access(4'($urandom_range(0, 15)), 1'($urandom), a, $urandom, $urandom,
                ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
